// File: rtl/gfx_strip_unpack_if.sv
// Strip-in / pixel-out handshake bundle for the strip unpacker.
// The master is the strip source and pixel sink, and the slave is the unpacker.
interface gfx_strip_unpack_if #(
   parameter int SW = 128
) ();
   logic [SW-1:0] strip_i;
   logic          strip_valid_i;
   logic          strip_ready_o;
   logic [31:0]   pixel_o;
   logic [15:0]   x_o;
   logic [15:0]   y_o;
   logic          pixel_valid_o;
   logic          pixel_ready_i;

   modport master (
      output strip_i, strip_valid_i, pixel_ready_i,
      input  strip_ready_o, pixel_o, x_o, y_o, pixel_valid_o
   );

   modport slave (
      input  strip_i, strip_valid_i, pixel_ready_i,
      output strip_ready_o, pixel_o, x_o, y_o, pixel_valid_o
   );
endinterface

// File: rtl/gfx_strip_unpack.sv
// Unpacks SW-bit frame-buffer strips into raster-ordered pixels tagged with (x, y).
// Each line starts on a fresh strip, and slots past the line end or the packed area are dropped.
module gfx_strip_unpack #(
   parameter int SW = 128,
   parameter int BN = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           color_depth_i,
   input  logic [15:0]          bmp_width_i,
   input  logic [15:0]          bmp_height_i,
   input  logic                 start_i,
   gfx_strip_unpack_if.slave    strm,
   output logic                 busy_o,
   output logic                 done_o
);
   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_FIN} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [1:0]    r_depth;
   logic [15:0]   r_width;
   logic [15:0]   r_height;
   logic [15:0]   r_x;
   logic [15:0]   r_y;
   logic [4:0]    r_k;
   logic [SW-1:0] r_shift;

   logic [BN:0]   w_bpp;
   logic [4:0]    w_pps;
   logic [31:0]   w_mask;
   logic          w_last_x;
   logic          w_last_y;
   logic          w_last_k;

   // Codes 0..3 are BPP8/16/24/32, and anything unrecognised falls back to 16 bpp.
   always_comb begin
      w_bpp  = (BN+1)'(16);
      w_pps  = 5'd8;
      w_mask = 32'h0000_FFFF;
      case (r_depth)
         2'd0: begin w_bpp = (BN+1)'(8);  w_pps = 5'd16; w_mask = 32'h0000_00FF; end
         2'd2: begin w_bpp = (BN+1)'(24); w_pps = 5'd5;  w_mask = 32'h00FF_FFFF; end
         2'd3: begin w_bpp = (BN+1)'(32); w_pps = 5'd4;  w_mask = 32'hFFFF_FFFF; end
         default: ;
      endcase
   end

   assign w_last_x = (r_x == r_width - 16'd1);
   assign w_last_y = (r_y == r_height - 16'd1);
   assign w_last_k = (r_k == w_pps - 5'd1);

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next             = r_state;
      strm.strip_ready_o = 1'b0;
      strm.pixel_valid_o = 1'b0;
      busy_o             = 1'b1;
      done_o             = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (start_i)
               w_next = (bmp_width_i == 16'd0 || bmp_height_i == 16'd0) ? S_FIN : S_LOAD;
         end
         S_LOAD: begin
            strm.strip_ready_o = 1'b1;
            if (strm.strip_valid_i) w_next = S_EMIT;
         end
         S_EMIT: begin
            strm.pixel_valid_o = 1'b1;
            if (strm.pixel_ready_i) begin
               if (w_last_x)      w_next = w_last_y ? S_FIN : S_LOAD;
               else if (w_last_k) w_next = S_LOAD;
            end
         end
         S_FIN: begin
            done_o = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_depth  <= 2'd0;
         r_width  <= 16'd0;
         r_height <= 16'd0;
         r_x      <= 16'd0;
         r_y      <= 16'd0;
         r_k      <= 5'd0;
         r_shift  <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start_i) begin
               r_depth  <= color_depth_i;
               r_width  <= bmp_width_i;
               r_height <= bmp_height_i;
               r_x      <= 16'd0;
               r_y      <= 16'd0;
               r_k      <= 5'd0;
            end
            S_LOAD: if (strm.strip_valid_i) begin
               r_shift <= strm.strip_i;
               r_k     <= 5'd0;
            end
            S_EMIT: if (strm.pixel_ready_i) begin
               if (w_last_x) begin
                  r_x <= 16'd0;
                  r_y <= r_y + 16'd1;
               end else begin
                  r_x <= r_x + 16'd1;
                  if (!w_last_k) begin
                     r_k     <= r_k + 5'd1;
                     r_shift <= r_shift >> w_bpp;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // The shift register only moves on acceptance, so the pixel holds while stalled.
   assign strm.pixel_o = r_shift[31:0] & w_mask;
   assign strm.x_o     = r_x;
   assign strm.y_o     = r_y;
endmodule

// File: doc/gfx_strip_unpack.md
# gfx_strip_unpack

Reads packed pixel strips fetched from the frame buffer and unpacks them into a stream of individual pixels tagged with their (x, y) coordinates. It is the read-side counterpart of the strip address and mask generator: that block places pixel x of line y at a bit offset inside an SW-bit strip, and this block recovers pixels and coordinates from consecutive strips in raster order. It sits between the memory read port and the blitter and readback datapath.

## Interface
- SW, 128, strip width in bits
- BN, 6, bit-index width minus one (log2(SW)-1)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- color_depth_i  in  2  BPP8/BPP16/BPP24/BPP32 code from gfx_pkg; latched at start
- bmp_width_i  in  16  pixels per line; latched at start
- bmp_height_i  in  16  lines; latched at start
- start_i  in  1  begin unpacking a bitmap; accepted only in IDLE
- strip_i  in  SW  strip data
- strip_valid_i  in  1  strip_i valid
- strip_ready_o  out  1  block can accept a strip
- pixel_o  out  32  pixel, zero-extended from bpp bits
- x_o  out  16  pixel x coordinate
- y_o  out  16  pixel y coordinate
- pixel_valid_o  out  1  pixel_o/x_o/y_o valid
- pixel_ready_i  in  1  downstream accepts pixel
- busy_o  out  1  not in IDLE
- done_o  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- Bits per pixel (bpp) is 8/16/24/32, with default 16. Pixels per strip is pps = floor(SW/bpp), which gives 16/8/5/4 at SW=128. Strip bits above pps*bpp are padding and are ignored.
- Slot k of a strip occupies bits [k*bpp+bpp-1 : k*bpp]. Slot 0 is the lowest x.
- Every line starts at slot 0 of a fresh strip. When x reaches width-1, any remaining slots of the current strip are discarded. Software programs width as a multiple of pps; the block behaves as above regardless.
- States:
  - IDLE: start_i latches depth, width and height, clears x, y and k. If width==0 or height==0, go to FIN. Otherwise go to LOAD.
  - LOAD: strip_ready_o=1. On strip_valid_i&strip_ready_o, capture strip into the shift register, set k=0, and go to EMIT.
  - EMIT: pixel_valid_o=1, and pixel_o = shift register low bpp bits. On pixel_ready_i:
    - If x==width-1 and y==height-1, go to FIN.
    - Else if x==width-1, set x=0, y=y+1, and go to LOAD.
    - Else if k==pps-1, set x=x+1 and go to LOAD.
    - Else set x=x+1, k=k+1, shift the register right by bpp, and stay in EMIT.
  - FIN: done_o=1 for one cycle, then go to IDLE.
- Counter widths:
  - x and y are 16 bits.
  - k is 5 bits.
  - Width/height comparisons use latched values. Inputs changing mid-frame have no effect.
- start_i outside IDLE is ignored.

## Timing
- Reset values:
  - strip_ready_o=0
  - pixel_valid_o=0
  - pixel_o=0
  - x_o=0
  - y_o=0
  - busy_o=0
  - done_o=0
  - state=IDLE
- rst asserted in any state abandons the frame next edge. No done_o is produced.
- start_i at edge n: busy_o=1 and strip_ready_o=1 from cycle n+1. For zero size, done_o=1 in cycle n+1.
- Strip handshake at edge n: pixel_valid_o=1 with slot 0 in cycle n+1. strip_ready_o is 0 throughout EMIT.
- pixel_o, x_o and y_o are registered and held stable while pixel_valid_o & !pixel_ready_i.
- Throughput with pixel_ready_i held at 1: pps+1 cycles per full strip, which is 1 LOAD cycle plus pps EMIT cycles.
- The last pixel accepted at edge n gives done_o=1 in cycle n+1 and busy_o=0 in cycle n+2.

## Test plan
- **BPP8, width 16, height 1, one strip of bytes 0x00..0x0F, ready always 1:**
  - 16 pixels 0x00..0x0F with x=0..15, y=0.
  - done_o 17 cycles after the strip handshake.
- **BPP24, width 5, height 2, two strips:**
  - Pixels are bits [23:0],[47:24]..[119:96]. Bits [127:120]=0xFF never appear.
  - Second strip yields y=1, x=0..4.
- **BPP16, width 12, height 1:**
  - Strip A gives x=0..7. Strip B gives x=8..11.
  - Slots 4..7 of B are discarded, and done_o follows x=11.
- **BPP32, width 4, height 1, pixel_ready_i toggling 1010:**
  - Each pixel is held stable until accepted.
  - Values and coordinates match, with no loss or duplication.
- **width 0, start_i:**
  - done_o one cycle later.
  - strip_ready_o and pixel_valid_o never assert.
- **rst during EMIT at x=3:**
  - All outputs return to reset values next cycle.
  - A following start_i restarts at x=0, y=0.
